// File: rtl/tdm_pkg.sv
// Shared types, default sizing and the 36-bit to 24-bit saturation used by the TDM transmitter.
package tdm_pkg;

    localparam int DWW_DEF         = 36;
    localparam int N_CH_DEF        = 8;
    localparam int SLOT_BITS_DEF   = 32;
    localparam int SAMPLE_BITS_DEF = 24;
    localparam int HEADROOM_DEF    = 4;
    localparam int BCLK_DIV_DEF    = 4;

    typedef logic [SAMPLE_BITS_DEF-1:0] sample_t;

    // The guard bits plus the field's own sign bit must all agree, otherwise clip to full scale.
    function automatic sample_t saturate(input logic signed [DWW_DEF-1:0] word);
        logic [HEADROOM_DEF:0] guard;
        guard = word[DWW_DEF-1 -: HEADROOM_DEF+1];
        if (guard == '0 || guard == '1)
            return word[DWW_DEF-1-HEADROOM_DEF -: SAMPLE_BITS_DEF];
        else if (word[DWW_DEF-1])
            return {1'b1, {(SAMPLE_BITS_DEF-1){1'b0}}};
        else
            return {1'b0, {(SAMPLE_BITS_DEF-1){1'b1}}};
    endfunction

endpackage

// File: rtl/tdm_bit_timer.sv
// Cycle, bit and slot counters for the TDM frame; strobes once per bit period at cycle count 0.
module tdm_bit_timer
    import tdm_pkg::*;
#(
    parameter int nChannels = N_CH_DEF,
    parameter int SlotBits  = SLOT_BITS_DEF,
    parameter int BclkDiv   = BCLK_DIV_DEF,
    parameter int BitW      = $clog2(SlotBits),
    parameter int SlotW     = (nChannels > 1) ? $clog2(nChannels) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             bit_strobe,
    output logic             bclk_next,
    output logic [BitW-1:0]  bit_idx,
    output logic [SlotW-1:0] slot_idx,
    output logic             frame_boundary
);

    localparam int CycW = (BclkDiv > 1) ? $clog2(BclkDiv) : 1;
    localparam logic [CycW-1:0]  LastCycle = CycW'(BclkDiv - 1);
    localparam logic [CycW-1:0]  HalfCycle = CycW'(BclkDiv / 2);
    localparam logic [BitW-1:0]  LastBit   = BitW'(SlotBits - 1);
    localparam logic [SlotW-1:0] LastSlot  = SlotW'(nChannels - 1);

    logic [CycW-1:0]  cycleCnt;
    logic [BitW-1:0]  bitCnt;
    logic [SlotW-1:0] slotCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCnt <= '0;
            bitCnt   <= '0;
            slotCnt  <= '0;
        end else begin
            cycleCnt <= (cycleCnt == LastCycle) ? '0 : cycleCnt + 1'b1;
            if (bit_strobe) begin
                if (bitCnt == LastBit) begin
                    bitCnt  <= '0;
                    slotCnt <= (slotCnt == LastSlot) ? '0 : slotCnt + 1'b1;
                end else begin
                    bitCnt <= bitCnt + 1'b1;
                end
            end
        end
    end

    // bclk is registered from the current count, so its falling edge lands on the strobe edge.
    assign bit_strobe     = (cycleCnt == '0);
    assign bclk_next      = (cycleCnt >= HalfCycle);
    assign bit_idx        = bitCnt;
    assign slot_idx       = slotCnt;
    assign frame_boundary = bit_strobe && (bitCnt == '0) && (slotCnt == '0);

endmodule

// File: rtl/tdm_transmitter.sv
// Double-buffered TDM serialiser: captures a saturated frame from the DSP core and shifts it out MSB first.
module tdm_transmitter
    import tdm_pkg::*;
#(
    parameter int DWW        = DWW_DEF,
    parameter int nChannels  = N_CH_DEF,
    parameter int SlotBits   = SLOT_BITS_DEF,
    parameter int SampleBits = SAMPLE_BITS_DEF,
    parameter int BclkDiv    = BCLK_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWW*nChannels-1:0] samples,
    input  logic                     sample_valid,
    input  logic                     clear_underrun,
    output logic                     frame_start,
    output logic                     bclk,
    output logic                     fsync,
    output logic                     sdata,
    output logic                     underrun
);

    localparam int BitW  = $clog2(SlotBits);
    localparam int SlotW = (nChannels > 1) ? $clog2(nChannels) : 1;

    logic             bitStrobe;
    logic             bclkNext;
    logic [BitW-1:0]  bitIdx;
    logic [SlotW-1:0] slotIdx;
    logic             frameBoundary;

    tdm_bit_timer #(
        .nChannels(nChannels),
        .SlotBits (SlotBits),
        .BclkDiv  (BclkDiv),
        .BitW     (BitW),
        .SlotW    (SlotW)
    ) bitTimer (
        .clk           (clk),
        .reset         (reset),
        .bit_strobe    (bitStrobe),
        .bclk_next     (bclkNext),
        .bit_idx       (bitIdx),
        .slot_idx      (slotIdx),
        .frame_boundary(frameBoundary)
    );

    sample_t shadow [nChannels];
    sample_t txBuf  [nChannels];
    logic    pending;
    logic    firstFrame;
    logic    underrunEvent;
    sample_t txWord;
    sample_t txShifted;
    logic    bitVal;

    assign underrunEvent = frameBoundary && !pending && !firstFrame;

    always_comb begin
        txWord    = txBuf[slotIdx];
        txShifted = txWord << bitIdx;
        bitVal    = (32'(bitIdx) < SampleBits) ? txShifted[SampleBits-1] : 1'b0;
    end

    // A strobe in the boundary cycle itself is late: it refills the shadow for the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < nChannels; k++) begin
                shadow[k] <= '0;
                txBuf[k]  <= '0;
            end
            pending    <= 1'b0;
            firstFrame <= 1'b1;
        end else begin
            if (frameBoundary) begin
                for (int k = 0; k < nChannels; k++)
                    txBuf[k] <= shadow[k];
                pending    <= 1'b0;
                firstFrame <= 1'b0;
            end
            if (sample_valid) begin
                for (int k = 0; k < nChannels; k++)
                    shadow[k] <= saturate(samples[k*DWW +: DWW]);
                pending <= 1'b1;
            end
        end
    end

    // The first bit of a frame comes straight from the shadow, as txBuf only loads on this same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            bclk        <= 1'b0;
            fsync       <= 1'b0;
            sdata       <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= frameBoundary;
            bclk        <= bclkNext;
            if (underrunEvent)
                underrun <= 1'b1;
            else if (clear_underrun)
                underrun <= 1'b0;
            if (bitStrobe) begin
                fsync <= frameBoundary;
                sdata <= frameBoundary ? shadow[0][SampleBits-1] : bitVal;
            end
        end
    end

endmodule

// File: doc/tdm_transmitter.md
Name: tdm_transmitter

Overview:
- Serialises the DSP core's 8 output words into a TDM audio stream: bit clock, frame sync and serial data.
- Double-buffers one frame of samples and supplies the DSP core's per-frame start pulse (frame_start → DSPCore start).
- Saturates the 36-bit internal fixed-point format to 24-bit samples.
- Sits between the DSP core outputs and the DAC/codec pins.

Parameters:
- DWW, 36, width of DSP data words
- nChannels, 8, TDM slots per frame
- SlotBits, 32, bit periods per slot
- SampleBits, 24, transmitted sample width (MSB first in the slot)
- Headroom, 4, guard bits above the transmitted field; sample field = word[DWW-1-Headroom -: SampleBits]
- BclkDiv, 4, clk cycles per bit period (even, ≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- samples  in  DWW×nChannels  DSP output words, sampled when sample_valid=1
- sample_valid  in  1  one-cycle strobe: samples hold a complete frame
- clear_underrun  in  1  clears the underrun flag
- frame_start  out  1  one-clk pulse at each frame boundary
- bclk  out  1  TDM bit clock
- fsync  out  1  frame sync, high during bit 0 of slot 0
- sdata  out  1  serial data
- underrun  out  1  sticky: a frame boundary occurred with no new samples

Behaviour:
- Reset (async, immediate, also mid-frame):
  - frame_start=0, bclk=0, fsync=0, sdata=0, underrun=0.
  - Counters, shadow buffer and shift buffer all cleared to 0.
  - pending=0, first_frame=1.
- Bit timing:
  - Cycle counter runs 0..BclkDiv-1.
  - bclk=0 for counts 0..BclkDiv/2-1 and 1 for the rest.
  - Bit strobe at count 0. Bit counter 0..SlotBits-1, slot counter 0..nChannels-1, both advanced on the bit strobe.
  - Outputs are registered and change only on the bit strobe, i.e. on the bclk falling edge. Receiver samples on the rising edge.
- Frame boundary: bit strobe with slot=0 and bit=0. First boundary is the first clk after reset deasserts. Period = nChannels·SlotBits·BclkDiv clk cycles (1024 by default).
- Shadow capture: sample_valid=1 loads every channel, saturated, into the shadow buffer and sets pending=1.
- At the boundary cycle:
  - Shadow is copied to the shift buffer; frame_start=1 for that one clk.
  - If pending=0 and first_frame=0, underrun is set and the previous shadow contents are re-sent.
  - pending and first_frame clear.
  - sample_valid in the boundary cycle itself counts as late. It loads the shadow and sets pending for the next frame (pending ends at 1), but does not affect the frame starting now.
- clear_underrun clears the flag. If it coincides with a new underrun event, the set wins.
- Slot layout:
  - Bits 0..SampleBits-1 carry the sample, MSB first.
  - Bits SampleBits..SlotBits-1 are 0.
- fsync=1 exactly for bit period 0 of slot 0, aligned with that bit's sdata.
- Saturation:
  - Let S = word[DWW-1-Headroom+... down to DWW-1-Headroom], i.e. the top Headroom+1 bits [35:31].
  - If all of S are equal, output = word[31:8].
  - Otherwise output = 0x7FFFFF if word[35]=0, or 0x800000 if word[35]=1.
- Latency:
  - Samples captured during frame N are transmitted in frame N+1.
  - sdata MSB of slot 0 appears on the boundary bit strobe.

Decomposition:
- tdm_pkg:
  - sample_t (logic[SampleBits-1:0]) and defaults for nChannels, SlotBits, SampleBits, Headroom.
  - Pure function saturate(word) → sample_t.
- Sub-module tdm_bit_timer:
  - Cycle, bit and slot counters.
  - Outputs bit_strobe, bclk_next, bit_idx, slot_idx, frame_boundary.
- Top level: shadow/shift buffers, pending/underrun logic, output registers.

Test Plan:
- Reset release, no sample_valid:
  - frame_start at cycle 0 and at cycle 1024.
  - sdata all 0; underrun set at cycle 1024, not at cycle 0.
- Timing checks:
  - bclk period is 4 clk, low for 2 then high for 2.
  - fsync high only during the first 4 clk of each frame.
  - sdata stable across every bclk rising edge.
- Channel data: samples[k] = 36'h0_0000_0100·(k+1), sample_valid during frame 0.
  - Frame 1 slot k carries 24'h00000(k+1) MSB first, then 8 zeros.
  - underrun stays 0.
- Saturation vectors:
  - 36'h1_0000_0000 → 24'h7FFFFF.
  - 36'hE_FFFF_FF00 → 24'h800000.
  - 36'hF_FFFF_FF00 → 24'hFFFFFF.
  - 36'h0_7FFF_FF00 → 24'h7FFFFF, unsaturated.
- Late strobe: sample_valid coincident with the frame-1 boundary, data A.
  - Frame 1 re-sends the old data and sets underrun.
  - Frame 2 sends A without flagging.
  - clear_underrun coincident with a new underrun leaves underrun=1.
- Reset mid-frame: assert reset at slot 3, bit 10.
  - All outputs go to 0 asynchronously.
  - After release, frame_start on the next clk; first frame sends zeros, no underrun.
